// File: rtl/bios_rom_arbiter_if.sv
// rtl/bios_rom_arbiter_if.sv - CPU, ioctl download and ROM RAM port signals of the BIOS ROM arbiter
interface bios_rom_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_hold;
  logic        dl_en;
  logic [7:0]  dl_index;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        dl_done;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dl_en, dl_index, dl_wr, dl_addr, dl_data,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_hold,
    output dl_wait, dl_done,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dl_en, dl_index, dl_wr, dl_addr, dl_data,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_hold,
    input  dl_wait, dl_done,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bios_rom_arbiter.sv
// rtl/bios_rom_arbiter.sv - shares the BIOS/BASIC ROM RAM port between CPU accesses and ioctl image download
// Optional macro BIOS_SHADOW_WR_EN: CPU writes reach the RAM (writable shadow); otherwise they are acked and dropped.
module bios_rom_arbiter #(
  parameter logic [15:0] BIOS_BASE  = 16'hE000,
  parameter logic [15:0] BASIC_BASE = 16'h6000
) (
  input logic             clk,
  input logic             reset,
  bios_rom_arbiter_if.slave bus
);

  localparam logic [16:0] BIOS_SPAN  = 17'h10000 - {1'b0, BIOS_BASE};
  localparam logic [16:0] BASIC_SPAN = {1'b0, BIOS_BASE} - {1'b0, BASIC_BASE};

  typedef enum logic [2:0] {IDLE, RD, RD_DATA, ACK, WR, DL_WR} state_t;

  state_t      state, state_n;
  logic        buf_full;
  logic [15:0] buf_addr;
  logic [7:0]  buf_data;
  logic        map_ok;
  logic [15:0] map_addr;
  logic        dl_accept;

  logic        mem_en_q, mem_we_q, mem_en_n, mem_we_n;
  logic [15:0] mem_addr_q, mem_addr_n;
  logic [7:0]  mem_wdata_q, mem_wdata_n;
  logic        cpu_ack_q, cpu_hold_q, dl_done_q;
  logic [7:0]  cpu_rdata_q;

  always_comb begin
    map_ok   = 1'b0;
    map_addr = 16'h0000;
    case (bus.dl_index)
      8'd0: begin
        map_ok   = {1'b0, bus.dl_addr} < BIOS_SPAN;
        map_addr = BIOS_BASE + bus.dl_addr;
      end
      8'd1: begin
        map_ok   = {1'b0, bus.dl_addr} < BASIC_SPAN;
        map_addr = BASIC_BASE + bus.dl_addr;
      end
      default: begin
        map_ok   = 1'b0;
        map_addr = 16'h0000;
      end
    endcase
  end

  // A strobe while the buffer is full is a protocol error and is simply not captured.
  assign dl_accept = bus.dl_wr && !buf_full && map_ok;

  always_comb begin
    state_n     = state;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    case (state)
      IDLE: begin
        if (buf_full) begin
          state_n     = DL_WR;
          mem_en_n    = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = buf_addr;
          mem_wdata_n = buf_data;
        end else if (bus.cpu_req) begin
          mem_addr_n  = bus.cpu_addr;
          mem_wdata_n = bus.cpu_wdata;
          if (bus.cpu_we) begin
            state_n = WR;
`ifdef BIOS_SHADOW_WR_EN
            mem_en_n = 1'b1;
            mem_we_n = 1'b1;
`else
            mem_en_n = 1'b0;
            mem_we_n = 1'b0;
`endif
          end else begin
            state_n  = RD;
            mem_en_n = 1'b1;
          end
        end else if (dl_accept) begin
          // Port is free: the byte is captured and written in the same cycle.
          state_n     = DL_WR;
          mem_en_n    = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = map_addr;
          mem_wdata_n = bus.dl_data;
        end
      end
      RD:      state_n = RD_DATA;
      RD_DATA: state_n = ACK;
      ACK:     state_n = IDLE;
      WR:      state_n = ACK;
      DL_WR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      buf_full    <= 1'b0;
      buf_addr    <= 16'h0000;
      buf_data    <= 8'h00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      cpu_hold_q  <= 1'b0;
      dl_done_q   <= 1'b0;
    end else begin
      state       <= state_n;
      mem_en_q    <= mem_en_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      cpu_ack_q   <= (state_n == ACK);
      if (state == RD_DATA) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
      if (dl_accept) begin
        buf_full <= 1'b1;
        buf_addr <= map_addr;
        buf_data <= bus.dl_data;
      end else if (state == DL_WR) begin
        buf_full <= 1'b0;
      end
      dl_done_q <= 1'b0;
      if (bus.dl_en) begin
        cpu_hold_q <= 1'b1;
      end else if (cpu_hold_q && state == IDLE && !buf_full && !dl_accept) begin
        cpu_hold_q <= 1'b0;
        dl_done_q  <= 1'b1;
      end
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.dl_wait   = buf_full;
  assign bus.dl_done   = dl_done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_bios_rom_arbiter.sv
// tb/tb_bios_rom_arbiter.sv - directed self-checking bench for bios_rom_arbiter with a registered-read RAM model
module tb_bios_rom_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   ack_count = 0;
  int   done_count = 0;

  logic [7:0]  ram [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [7:0]  pre_data = 8'h00;

  bios_rom_arbiter_if bus();

  bios_rom_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  always @(posedge clk) begin
    if (bus.cpu_ack) ack_count <= ack_count + 1;
    if (bus.dl_done) done_count <= done_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  initial begin
    int acks0;
    int dones0;
    int n;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
    bus.dl_en = 1'b0; bus.dl_index = 8'h00; bus.dl_wr = 1'b0; bus.dl_addr = 16'h0000; bus.dl_data = 8'h00;
    bus.mem_rdata = 8'h00;

    preload(16'hFFF0, 8'hEA);
    preload(16'hE100, 8'h3C);
    preload(16'h6001, 8'hA5);
    tick();
    check("rst_cpu_ack",   bus.cpu_ack,   1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("rst_cpu_hold",  bus.cpu_hold,  1'b0);
    check("rst_dl_wait",   bus.dl_wait,   1'b0);
    check("rst_dl_done",   bus.dl_done,   1'b0);
    check("rst_mem",       {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 26'h0);

    // read after reset
    reset = 1'b0;
    tick();
    acks0 = ack_count;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hFFF0;
    tick();
    check("rd_mem_en",   bus.mem_en,   1'b1);
    check("rd_mem_addr", bus.mem_addr, 16'hFFF0);
    check("rd_ack_n",    bus.cpu_ack,  1'b0);
    tick();
    check("rd_mem_en_off", bus.mem_en, 1'b0);
    check("rd_ack_n1",     bus.cpu_ack, 1'b0);
    tick();
    check("rd_ack",   bus.cpu_ack,   1'b1);
    check("rd_rdata", bus.cpu_rdata, 8'hEA);
    bus.cpu_req = 1'b0;
    tick();
    check("rd_ack_clear", bus.cpu_ack,   1'b0);
    check("rd_rdata_hold", bus.cpu_rdata, 8'hEA);
    tick();
    tick();
    check("rd_one_ack", ack_count - acks0, 1);

    // BIOS download
    dones0 = done_count;
    bus.dl_en = 1'b1; bus.dl_index = 8'd0;
    tick();
    check("bios_hold", bus.cpu_hold, 1'b1);
    bus.dl_wr = 1'b1; bus.dl_addr = 16'h0000; bus.dl_data = 8'h55;
    tick();
    bus.dl_wr = 1'b0;
    check("bios_wait_set", bus.dl_wait, 1'b1);
    check("bios_mem_wr",   {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {2'b11, 16'hE000, 8'h55});
    tick();
    check("bios_wait_clr", bus.dl_wait, 1'b0);
    check("bios_ram_e000", ram[16'hE000], 8'h55);
    bus.dl_wr = 1'b1; bus.dl_addr = 16'h1FFF; bus.dl_data = 8'hAA;
    tick();
    bus.dl_wr = 1'b0;
    tick();
    check("bios_ram_ffff", ram[16'hFFFF], 8'hAA);
    bus.dl_wr = 1'b1; bus.dl_addr = 16'h2000; bus.dl_data = 8'h99;
    tick();
    bus.dl_wr = 1'b0;
    check("bios_oow_wait", bus.dl_wait, 1'b0);
    check("bios_oow_en",   bus.mem_en,  1'b0);
    tick();
    check("bios_hold_end", bus.cpu_hold, 1'b1);
    bus.dl_en = 1'b0;
    tick();
    check("bios_done",      bus.dl_done,  1'b1);
    check("bios_hold_fall", bus.cpu_hold, 1'b0);
    tick();
    check("bios_done_once", done_count - dones0, 1);

    // BASIC download
    bus.dl_en = 1'b1; bus.dl_index = 8'd1;
    tick();
    bus.dl_wr = 1'b1; bus.dl_addr = 16'h7FFF; bus.dl_data = 8'h12;
    tick();
    bus.dl_wr = 1'b0;
    check("basic_mem_addr", bus.mem_addr, 16'hDFFF);
    tick();
    check("basic_ram_dfff", ram[16'hDFFF], 8'h12);
    bus.dl_wr = 1'b1; bus.dl_addr = 16'h8000; bus.dl_data = 8'h77;
    tick();
    check("basic_oow", {bus.dl_wait, bus.mem_en}, 2'b00);
    bus.dl_index = 8'd2; bus.dl_addr = 16'h0000; bus.dl_data = 8'h66;
    tick();
    bus.dl_wr = 1'b0;
    check("idx2_drop", {bus.dl_wait, bus.mem_en}, 2'b00);
    tick();

    // contention: CPU read accepted on the same edge as a download strobe
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hDFFF;
    bus.dl_wr = 1'b1; bus.dl_index = 8'd1; bus.dl_addr = 16'h0000; bus.dl_data = 8'h34;
    tick();
    check("cont_rd_first", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 16'hDFFF});
    check("cont_wait",     bus.dl_wait, 1'b1);
    bus.dl_addr = 16'h0001; bus.dl_data = 8'h56;
    tick();
    bus.dl_wr = 1'b0;
    check("cont_wait_rd_data", bus.dl_wait, 1'b1);
    tick();
    check("cont_ack",      bus.cpu_ack,   1'b1);
    check("cont_rdata",    bus.cpu_rdata, 8'h12);
    check("cont_wait_ack", bus.dl_wait,   1'b1);
    bus.cpu_req = 1'b0;
    n = 0;
    while (bus.dl_wait && n < 6) begin
      tick();
      n++;
    end
    check("cont_wait_clear", bus.dl_wait, 1'b0);
    tick();
    check("cont_ram_6000",   ram[16'h6000], 8'h34);
    check("cont_dropped",    ram[16'h6001], 8'hA5);
    bus.dl_en = 1'b0;
    tick();
    tick();

    // CPU write to the BIOS window, then read back
    acks0 = ack_count;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'hE100; bus.cpu_wdata = 8'h77;
    tick();
`ifdef BIOS_SHADOW_WR_EN
    check("wr_mem_en", {bus.mem_en, bus.mem_we}, 2'b11);
`else
    check("wr_mem_en", {bus.mem_en, bus.mem_we}, 2'b00);
`endif
    tick();
    check("wr_ack", bus.cpu_ack, 1'b1);
    bus.cpu_req = 1'b0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hE100;
    tick();
    tick();
    tick();
    check("wr_rb_ack", bus.cpu_ack, 1'b1);
`ifdef BIOS_SHADOW_WR_EN
    check("wr_readback", bus.cpu_rdata, 8'h77);
`else
    check("wr_readback", bus.cpu_rdata, 8'h3C);
`endif
    bus.cpu_req = 1'b0;
    tick();
    check("wr_ack_count", ack_count - acks0, 2);

    // reset while the read is in RD_DATA
    bus.dl_en = 1'b1;
    tick();
    acks0 = ack_count;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hFFF0;
    tick();
    tick();
    reset = 1'b1; bus.cpu_req = 1'b0;
    tick();
    check("rst_mid_rdata", bus.cpu_rdata, 8'h00);
    check("rst_mid_hold",  bus.cpu_hold,  1'b0);
    reset = 1'b0;
    tick();
    check("rst_mid_hold_back", bus.cpu_hold, 1'b1);
    tick();
    tick();
    check("rst_mid_no_ack", ack_count - acks0, 0);
    bus.dl_en = 1'b0;
    tick();
    check("rst_mid_done", bus.dl_done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
